// File: rtl/mpe_out_collector_pkg.sv
// rtl/mpe_out_collector_pkg.sv - shared types, geometry defaults and width helpers for the MPE output collector
package mpe_out_collector_pkg;

  typedef logic [15:0] fp16_t;

  // Default result tile geometry, kept in step with the MPE array
  localparam int MPE_DIMM1 = 2;
  localparam int MPE_DIMM2 = 1;

  // Pointer width for a power-of-two slot count (never narrower than one bit)
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width able to hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mpe_tile_fifo.sv
// rtl/mpe_tile_fifo.sv - whole-tile FIFO with id tagging, pointers and registered count
module mpe_tile_fifo
  import mpe_out_collector_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TILE_W = 32,
  parameter int TID_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [TILE_W-1:0]      push_tile,
  input  logic                   pop,
  output logic [TILE_W-1:0]      head_tile,
  output logic [TID_W-1:0]       head_id,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [TILE_W-1:0] mem [DEPTH];
  logic [TID_W-1:0]  ids [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [TID_W-1:0]  id_cnt;
  logic [CW-1:0]     cnt_q;

  // Slot payload and id tag; the caller only pushes when a slot is free this cycle
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_tile;
      ids[wr_ptr] <= id_cnt;
    end
  end

  // Pointers, id counter and occupancy count; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      id_cnt <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        id_cnt <= id_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_tile = mem[rd_ptr];
  assign head_id   = ids[rd_ptr];
  assign count     = cnt_q;
  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);

endmodule

// File: rtl/mpe_out_collector.sv
// rtl/mpe_out_collector.sv - captures MPE result tiles and serializes them row-major onto a valid/ready stream
module mpe_out_collector
  import mpe_out_collector_pkg::*;
#(
  parameter int ROWS  = MPE_DIMM1,
  parameter int COLS  = MPE_DIMM2,
  parameter int LANES = 1,
  parameter int DEPTH = 4,
  parameter int TID_W = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [ROWS-1:0][COLS-1:0][15:0]  in_mm,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0][15:0]           out_data,
  output logic                             out_last,
  output logic [TID_W-1:0]                 out_tile_id,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH):0]           occupancy,
  output logic                             overflow,
  input  logic                             clr_ovf
);

  localparam int BEATS  = ROWS * COLS / LANES;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TILE_W = ROWS * COLS * 16;

  logic [BW-1:0]          beat_cnt;
  logic                   last_beat;
  logic                   beat_xfer;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   ovf_q;
  logic [TILE_W-1:0]      head_tile;
  logic [TID_W-1:0]       head_id;
  logic [$clog2(DEPTH):0] count;

  // Packed in_mm already places element r*COLS+c at bit offset 16*(r*COLS+c)
  mpe_tile_fifo #(
    .DEPTH  (DEPTH),
    .TILE_W (TILE_W),
    .TID_W  (TID_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_tile (in_mm),
    .pop       (pop),
    .head_tile (head_tile),
    .head_id   (head_id),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid   = !empty;
  assign last_beat   = (beat_cnt == BW'(BEATS - 1));
  assign out_last    = last_beat && out_valid;
  assign beat_xfer   = out_valid && out_ready;
  assign pop         = beat_xfer && last_beat;
  // A full FIFO still takes a tile when the head's final beat leaves this cycle
  assign push        = in_valid && (!full || pop);
  assign drop        = in_valid && full && !pop;
  assign occupancy   = count;
  assign out_tile_id = out_valid ? head_id : '0;
  assign overflow    = ovf_q;

  // Lane mux: beat b carries element b*LANES+l on lane l; zero while idle
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int l = 0; l < LANES; l++) begin
        out_data[l] = fp16_t'(head_tile[(int'(beat_cnt) * LANES + l) * 16 +: 16]);
      end
    end
  end

  // Beat position within the head tile, restarting when the tile completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (beat_xfer) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mpe_out_collector.sv
// tb/tb_mpe_out_collector.sv - directed self-checking bench for mpe_out_collector
module tb_mpe_out_collector;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic [1:0][0:0][15:0] in_mm;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:0][15:0]      out_data;
  logic                  out_last;
  logic [7:0]            out_tile_id;
  logic                  full;
  logic                  empty;
  logic [2:0]            occupancy;
  logic                  overflow;
  logic                  clr_ovf;

  int n_vec;
  int n_err;

  mpe_out_collector #(
    .ROWS  (2),
    .COLS  (1),
    .LANES (1),
    .DEPTH (4),
    .TID_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_mm       (in_mm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_tile_id (out_tile_id),
    .full        (full),
    .empty       (empty),
    .occupancy   (occupancy),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    in_mm     = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_tile(input logic [15:0] e1, input logic [15:0] e0);
    in_mm    = {e1, e0};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] tile_e(input int k, input int e);
    return 16'(16'h1000 * (k + 1) + e);
  endfunction

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    in_mm     = '0;

    // Reset state
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_tile_id", out_tile_id, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_overflow", overflow, 0);
    do_reset();

    // Single tile with out_ready held high
    out_ready = 1'b1;
    push_tile(16'h4000, 16'h3C00);
    check("t1_b0_valid", out_valid, 1);
    check("t1_b0_data", out_data, 16'h3C00);
    check("t1_b0_last", out_last, 0);
    check("t1_b0_id", out_tile_id, 0);
    tick();
    check("t1_b1_data", out_data, 16'h4000);
    check("t1_b1_last", out_last, 1);
    tick();
    check("t1_empty", empty, 1);
    check("t1_valid_low", out_valid, 0);

    // Backpressure holds the head beat stable
    do_reset();
    push_tile(16'h2222, 16'h1111);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 16'h1111);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_b0", out_data, 16'h1111);
    check("bp_rel_id", out_tile_id, 0);
    tick();
    check("bp_rel_b1", out_data, 16'h2222);
    check("bp_rel_last", out_last, 1);
    tick();
    check("bp_empty", empty, 1);

    // Fill to full, fifth tile dropped
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_tile(tile_e(k, 1), tile_e(k, 0));
      if (k == 3) begin
        check("fill_full4", full, 1);
        check("fill_occ4", occupancy, 4);
        check("fill_ovf4", overflow, 0);
      end
    end
    check("fill_ovf5", overflow, 1);
    check("fill_occ5", occupancy, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_id_b0", out_tile_id, k);
      check("drain_data_b0", out_data, tile_e(k, 0));
      check("drain_last_b0", out_last, 0);
      tick();
      check("drain_id_b1", out_tile_id, k);
      check("drain_data_b1", out_data, tile_e(k, 1));
      check("drain_last_b1", out_last, 1);
      tick();
    end
    check("drain_empty", empty, 1);
    push_tile(16'hBEEF, 16'hCAFE);
    check("after_drop_id", out_tile_id, 4);
    check("after_drop_occ", occupancy, 1);

    // Full with a push in the same cycle as the head's last beat
    do_reset();
    for (int k = 0; k < 4; k++) push_tile(tile_e(k, 1), tile_e(k, 0));
    check("sim_full", full, 1);
    out_ready = 1'b1;
    tick();
    check("sim_head_last", out_last, 1);
    in_mm    = {tile_e(4, 1), tile_e(4, 0)};
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("sim_occ", occupancy, 4);
    check("sim_full_kept", full, 1);
    check("sim_ovf", overflow, 0);
    check("sim_head_id", out_tile_id, 1);
    check("sim_head_data", out_data, tile_e(1, 0));
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("sim_tail_id", out_tile_id, 4);
    check("sim_tail_data", out_data, tile_e(4, 0));
    check("sim_tail_occ", occupancy, 1);

    // Overflow clear, and a clear coinciding with a drop
    do_reset();
    for (int k = 0; k < 5; k++) push_tile(tile_e(k, 1), tile_e(k, 0));
    check("clr_pre", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_done", overflow, 0);
    in_mm    = {tile_e(9, 1), tile_e(9, 0)};
    in_valid = 1'b1;
    clr_ovf  = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    check("clr_vs_drop", overflow, 1);
    check("clr_vs_drop_occ", occupancy, 4);

    // Asynchronous reset in the middle of a tile
    do_reset();
    push_tile(16'h5555, 16'h4444);
    out_ready = 1'b1;
    tick();
    check("mid_b1_data", out_data, 16'h5555);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_occ", occupancy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_post_valid0", out_valid, 0);
    tick();
    check("mid_post_valid1", out_valid, 0);
    out_ready = 1'b0;
    push_tile(16'h7777, 16'h6666);
    check("mid_new_id", out_tile_id, 0);
    check("mid_new_data", out_data, 16'h6666);
    check("mid_new_last", out_last, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mpe_out_collector.md
Name: mpe_out_collector

Overview:
- Output stage directly downstream of the MPE.
- Captures each finished FP16 result tile (MPE outMM/outValid) into a small tile FIFO and serializes it row-major onto a valid/ready output stream toward the writeback path.
- Decouples the MPE's single-cycle result pulse from a backpressured consumer.
- Reports occupancy and a sticky overflow flag for tiles dropped while full.

Parameters:
- ROWS, 2, result tile rows (matches MPE Dimm1)
- COLS, 1, result tile columns (matches MPE Dimm2)
- LANES, 1, FP16 elements per output beat; ROWS*COLS must be a multiple of LANES
- DEPTH, 4, tile slots in FIFO; power of two, >=2
- TID_W, 8, width of the tile sequence id

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  one-cycle pulse; in_mm holds a complete tile this cycle
- in_mm  in  [ROWS-1:0][COLS-1:0][15:0]  FP16 result tile
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  [LANES-1:0][15:0]  FP16 elements of current beat
- out_last  out  1  current beat is the last of its tile
- out_tile_id  out  TID_W  sequence id of the tile being emitted
- full  out  1  DEPTH tiles stored
- empty  out  1  no tiles stored
- occupancy  out  $clog2(DEPTH)+1  tiles stored (including the one being emitted)
- overflow  out  1  sticky: a tile was dropped
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_tile_id=0.
  - full=0, empty=1, occupancy=0, overflow=0.
  - Pointers, beat counter and id counter are 0.
  - Reset mid-stream discards all stored tiles; no partial beats appear after release.
- Storage: DEPTH x ROWS x COLS x 16-bit registers; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH; count is a separate register.
- Push:
  - At a rising edge with in_valid=1 and the tile accepted, in_mm is written to slot wr_ptr.
  - The slot's id is tagged with id_cnt, then wr_ptr++, id_cnt++ (wraps at 2^TID_W).
- Flattening and lane mapping:
  - Element index e = r*COLS + c.
  - Beat b carries element b*LANES+l on lane l.
  - BEATS = ROWS*COLS/LANES.
- Pop:
  - A beat transfers when out_valid && out_ready.
  - beat_cnt counts 0..BEATS-1.
  - out_last = (beat_cnt==BEATS-1) && out_valid.
  - On transfer of the last beat: beat_cnt->0, rd_ptr++, count--.
- Output state:
  - out_valid = !empty.
  - out_data, out_tile_id and out_last are combinational from slot rd_ptr and beat_cnt.
  - They stay stable while out_valid && !out_ready.
- Latency: a tile pushed into an empty FIFO at edge N gives out_valid=1 in the cycle after edge N (1-cycle latency). Minimum output is BEATS cycles per tile at out_ready=1.
- Full handling:
  - When full, in_valid is accepted only if the last beat of the head tile transfers in the same cycle (count unchanged, both pointers advance).
  - Otherwise the tile is dropped: nothing is written, id_cnt is unchanged, overflow<=1.
- Simultaneous push and last-beat pop when not full: count unchanged.
- Push into an empty FIFO never bypasses storage; data appears next cycle.
- Flag priority: overflow set and clr_ovf in the same cycle leaves overflow=1.
- full = (count==DEPTH); empty = (count==0); occupancy = count. All are registered-count derived.
- Data is treated as opaque 16-bit; no arithmetic on FP16 values.

Decomposition:
- Shared package holds:
  - the fp16_t typedef (logic [15:0]);
  - the function clog2-based ptr/count width helper;
  - default tile geometry constants shared with MPE (MPE_DIMM1, MPE_DIMM2).
- One natural sub-module: mpe_tile_fifo, covering storage, pointers, count, full/empty and id tags.
- The top holds the beat serializer, out_last/lane mux and overflow flag.

Test Plan:
- Single tile, out_ready=1, ROWS=2 COLS=1 LANES=1: in_mm={0x4000,0x3C00} at edge 0 -> edge 1: out_data=0x3C00 (e=0), out_last=0, id=0; edge 2: out_data=0x4000, out_last=1; then empty=1.
- Backpressure: push a tile, hold out_ready=0 for 5 cycles -> out_valid=1 and out_data constant for all 5; release -> 2 beats, tile id 0.
- Fill/overflow, DEPTH=4, out_ready=0: 5 pulses -> full=1 after 4th, occupancy=4, overflow=1 after 5th; output ids 0,1,2,3 in order, 5th tile absent; next accepted tile gets id 4.
- Full with simultaneous last-beat pop: full, out_ready=1 on beat 1 of head, in_valid same cycle -> accepted, occupancy stays 4, overflow stays 0.
- clr_ovf: overflow=1, clr_ovf pulse -> overflow=0 next cycle; clr_ovf coincident with a dropped tile -> overflow remains 1.
- Reset mid-emission: assert rst_n=0 after beat 0 of a tile -> out_valid=0, empty=1, occupancy=0 immediately (async); after release no beat 1 appears; the next pushed tile gets id 0.
